// File: rtl/i2c_regbank.sv
// Application-side register bank behind the I2C slave engine: ID, control, sticky status,
// eight general-purpose registers and a pair of byte FIFOs to/from a valid/ready stream.
module i2c_regbank #(
   parameter logic [7:0] ID_VALUE = 8'hA5,
   parameter int         FIFO_AW  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rw,
   input  logic [7:0]  addr,
   input  logic        wen,
   input  logic [7:0]  wdata,
   input  logic        rdata_used,
   output logic [7:0]  rdata,
   output logic [7:0]  ctrl,
   output logic [63:0] gp_out,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW    = FIFO_AW + 1;

   logic [7:0]         r_txMem [DEPTH];
   logic [7:0]         r_rxMem [DEPTH];
   logic [FIFO_AW-1:0] r_txWp, r_txRp, r_rxWp, r_rxRp;
   logic [CW-1:0]      r_txCnt, r_rxCnt;
   logic [7:0]         r_gp [8];
   logic [7:0]         r_ctrl;
   logic [7:0]         r_rdata;
   logic               r_txOvf, r_rxUnf;

   logic               w_txEmpty, w_txFull, w_rxEmpty, w_rxFull;
   logic               w_txReq, w_txPush, w_txPop;
   logic               w_rxPopReq, w_rxPop, w_rxPush;
   logic               w_clrReq;
   logic [FIFO_AW-1:0] w_rxRpNext;
   logic [7:0]         w_rxNextHead;
   logic [7:0]         w_rdMux;
   logic               w_unused;

   assign w_unused   = rw;

   assign w_txEmpty  = (r_txCnt == '0);
   assign w_txFull   = (r_txCnt == CW'(DEPTH));
   assign w_rxEmpty  = (r_rxCnt == '0);
   assign w_rxFull   = (r_rxCnt == CW'(DEPTH));

   assign w_txPop    = !w_txEmpty && tx_ready;
   assign w_txReq    = wen && (addr == 8'h04);
   assign w_txPush   = w_txReq && (!w_txFull || w_txPop);

   // A full RX FIFO still takes a byte in the cycle the I2C side pops, so ready follows that.
   assign w_rxPopReq = rdata_used && (addr == 8'h05);
   assign w_rxPop    = w_rxPopReq && !w_rxEmpty;
   assign rx_ready   = !w_rxFull || w_rxPop;
   assign w_rxPush   = rx_valid && rx_ready;

   assign w_clrReq   = wen && (addr == 8'h03);

   assign tx_valid   = !w_txEmpty;
   assign tx_data    = w_txEmpty ? 8'h00 : r_txMem[r_txRp];
   assign ctrl       = r_ctrl;
   assign rdata      = r_rdata;

   for (genvar g = 0; g < 8; g++) begin : gen_gp
      assign gp_out[g*8 +: 8] = r_gp[g];
   end

   assign w_rxRpNext   = r_rxRp + 1'b1;
   assign w_rxNextHead = (r_rxCnt > CW'(1)) ? r_rxMem[w_rxRpNext] :
                         (w_rxPush ? rx_data : 8'h00);

   always_comb begin
      w_rdMux = 8'h00;
      case (addr)
         8'h00: w_rdMux = ID_VALUE;
         8'h01: w_rdMux = r_ctrl;
         8'h02: w_rdMux = {2'b00, r_rxUnf, r_txOvf, w_rxFull, w_rxEmpty, w_txFull, w_txEmpty};
         8'h05: w_rdMux = w_rxEmpty ? 8'h00 : r_rxMem[r_rxRp];
         8'h06: w_rdMux = {{(8-CW){1'b0}}, r_txCnt};
         8'h07: w_rdMux = {{(8-CW){1'b0}}, r_rxCnt};
         default: begin
            if (addr[7:3] == 5'b00001) begin
               w_rdMux = r_gp[addr[2:0]];
            end
         end
      endcase
   end

   // Storage carries no reset; the counts alone decide what is valid.
   always_ff @(posedge clk) begin
      if (w_txPush) begin
         r_txMem[r_txWp] <= wdata;
      end
      if (w_rxPush) begin
         r_rxMem[r_rxWp] <= rx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txWp  <= '0;
         r_txRp  <= '0;
         r_txCnt <= '0;
         r_rxWp  <= '0;
         r_rxRp  <= '0;
         r_rxCnt <= '0;
      end else begin
         if (w_txPush) r_txWp <= r_txWp + 1'b1;
         if (w_txPop)  r_txRp <= r_txRp + 1'b1;
         if (w_txPush && !w_txPop)      r_txCnt <= r_txCnt + 1'b1;
         else if (!w_txPush && w_txPop) r_txCnt <= r_txCnt - 1'b1;
         if (w_rxPush) r_rxWp <= r_rxWp + 1'b1;
         if (w_rxPop)  r_rxRp <= r_rxRp + 1'b1;
         if (w_rxPush && !w_rxPop)      r_rxCnt <= r_rxCnt + 1'b1;
         else if (!w_rxPush && w_rxPop) r_rxCnt <= r_rxCnt - 1'b1;
      end
   end

   // Sticky error flags: a set in the same cycle as a clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txOvf <= 1'b0;
         r_rxUnf <= 1'b0;
      end else begin
         if (w_txReq && w_txFull && !w_txPop) r_txOvf <= 1'b1;
         else if (w_clrReq && wdata[4])       r_txOvf <= 1'b0;
         if (w_rxPopReq && w_rxEmpty)         r_rxUnf <= 1'b1;
         else if (w_clrReq && wdata[5])       r_rxUnf <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ctrl <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            r_gp[i] <= 8'h00;
         end
      end else if (wen) begin
         if (addr == 8'h01) begin
            r_ctrl <= wdata;
         end
         if (addr[7:3] == 5'b00001) begin
            r_gp[addr[2:0]] <= wdata;
         end
      end
   end

   // On an RX pop the following head is loaded directly so it is visible one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= 8'h00;
      end else if (w_rxPop) begin
         r_rdata <= w_rxNextHead;
      end else begin
         r_rdata <= w_rdMux;
      end
   end

endmodule

// File: tb/tb_i2c_regbank.sv
// Self-checking bench for i2c_regbank: directed scenarios plus randomized traffic
// compared against a queue-based model of the register map.
module tb_i2c_regbank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rw = 1'b0;
   logic [7:0]  addr = 8'h00;
   logic        wen = 1'b0;
   logic [7:0]  wdata = 8'h00;
   logic        rdata_used = 1'b0;
   logic [7:0]  rdata;
   logic [7:0]  ctrl;
   logic [63:0] gp_out;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;

   int checks = 0;
   int errors = 0;

   logic [7:0] txQ[$];
   logic [7:0] rxQ[$];
   logic [7:0] mCtrl;
   logic [7:0] mGp [8];
   logic       mOvf, mUnf;

   i2c_regbank #(.ID_VALUE(8'hA5), .FIFO_AW(2)) dut (
      .clk(clk), .rst_n(rst_n), .rw(rw), .addr(addr), .wen(wen), .wdata(wdata),
      .rdata_used(rdata_used), .rdata(rdata), .ctrl(ctrl), .gp_out(gp_out),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
   );

   always #5 clk = ~clk;

   function automatic void modelReset();
      txQ.delete();
      rxQ.delete();
      mCtrl = 8'h00;
      for (int i = 0; i < 8; i++) mGp[i] = 8'h00;
      mOvf = 1'b0;
      mUnf = 1'b0;
   endfunction

   function automatic logic [7:0] expRead(input logic [7:0] a);
      logic [7:0] v;
      v = 8'h00;
      if (a == 8'h00) v = 8'hA5;
      else if (a == 8'h01) v = mCtrl;
      else if (a == 8'h02) v = {2'b00, mUnf, mOvf, rxQ.size() == 4, rxQ.size() == 0,
                                txQ.size() == 4, txQ.size() == 0};
      else if (a == 8'h05) v = (rxQ.size() > 0) ? rxQ[0] : 8'h00;
      else if (a == 8'h06) v = 8'(txQ.size());
      else if (a == 8'h07) v = 8'(rxQ.size());
      else if (a >= 8'h08 && a <= 8'h0F) v = mGp[a - 8'h08];
      return v;
   endfunction

   function automatic logic [63:0] expGp();
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = mGp[i];
      return v;
   endfunction

   // One clock; the application drains one TX byte whenever it is ready and data is present.
   task automatic step();
      if (tx_ready && txQ.size() > 0) void'(txQ.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
      addr = a; wdata = d; wen = 1'b1;
      step();
      wen = 1'b0;
      if (a == 8'h01) mCtrl = d;
      else if (a == 8'h03) begin
         if (d[4]) mOvf = 1'b0;
         if (d[5]) mUnf = 1'b0;
      end else if (a == 8'h04) begin
         if (txQ.size() < 4) txQ.push_back(d);
         else mOvf = 1'b1;
      end else if (a >= 8'h08 && a <= 8'h0F) mGp[a - 8'h08] = d;
   endtask

   task automatic readReg(input logic [7:0] a, output logic [7:0] v);
      addr = a;
      step();
      step();
      v = rdata;
   endtask

   task automatic pushRx(input logic [7:0] d);
      rx_data = d; rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      if (rxQ.size() < 4) rxQ.push_back(d);
   endtask

   task automatic popRx();
      addr = 8'h05; rdata_used = 1'b1;
      step();
      rdata_used = 1'b0;
      if (rxQ.size() > 0) void'(rxQ.pop_front());
      else mUnf = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] v;
      #2;
      checks++;
      if ({rdata, ctrl, tx_data, tx_valid, rx_ready} !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got rdata=%h ctrl=%h tx_data=%h tx_valid=%b rx_ready=%b expected 00 00 00 0 1",
                  rdata, ctrl, tx_data, tx_valid, rx_ready);
      end
      checks++;
      if (gp_out !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_gp: got %h expected 0", gp_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      readReg(8'h00, v);
      checks++;
      if (v !== expRead(8'h00)) begin
         errors++;
         $display("[TB] FAIL id_read: got %h expected %h", v, expRead(8'h00));
      end
      readReg(8'h02, v);
      checks++;
      if (v !== 8'h05) begin
         errors++;
         $display("[TB] FAIL reset_status: got %h expected 05", v);
      end
   endtask

   task automatic test_gp();
      logic [7:0] v;
      writeReg(8'h0B, 8'h3C);
      checks++;
      if (gp_out[31:24] !== 8'h3C) begin
         errors++;
         $display("[TB] FAIL gp_out_byte3: got %h expected 3c", gp_out[31:24]);
      end
      readReg(8'h0B, v);
      checks++;
      if (v !== 8'h3C) begin
         errors++;
         $display("[TB] FAIL gp_readback: got %h expected 3c", v);
      end
      writeReg(8'h20, 8'h77);
      readReg(8'h20, v);
      checks++;
      if (v !== 8'h00) begin
         errors++;
         $display("[TB] FAIL unmapped_read: got %h expected 00", v);
      end
      writeReg(8'h01, 8'h5A);
      checks++;
      if (ctrl !== 8'h5A) begin
         errors++;
         $display("[TB] FAIL ctrl_write: got %h expected 5a", ctrl);
      end
   endtask

   task automatic test_tx_fifo();
      logic [7:0] v;
      for (int i = 0; i < 5; i++) writeReg(8'h04, 8'h11 + 8'(i));
      readReg(8'h06, v);
      checks++;
      if (v !== 8'h04) begin
         errors++;
         $display("[TB] FAIL tx_level_full: got %h expected 04", v);
      end
      readReg(8'h02, v);
      checks++;
      if (v !== 8'h16 || v !== expRead(8'h02)) begin
         errors++;
         $display("[TB] FAIL tx_ovf_status: got %h expected 16", v);
      end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== txQ[0]) begin
            errors++;
            $display("[TB] FAIL tx_drain_%0d: got valid=%b data=%h expected valid=1 data=%h",
                     i, tx_valid, tx_data, txQ[0]);
         end
         step();
      end
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL tx_drained: got tx_valid=%b expected 0", tx_valid);
      end
      writeReg(8'h03, 8'h10);
      readReg(8'h02, v);
      checks++;
      if (v !== 8'h05) begin
         errors++;
         $display("[TB] FAIL tx_ovf_clear: got %h expected 05", v);
      end
   endtask

   task automatic test_rx_fifo();
      logic [7:0] v;
      pushRx(8'hA1);
      pushRx(8'hA2);
      readReg(8'h05, v);
      checks++;
      if (v !== 8'hA1) begin
         errors++;
         $display("[TB] FAIL rx_head: got %h expected a1", v);
      end
      popRx();
      step();
      checks++;
      if (rdata !== 8'hA2) begin
         errors++;
         $display("[TB] FAIL rx_second: got %h expected a2", rdata);
      end
      popRx();
      step();
      checks++;
      if (rdata !== 8'h00) begin
         errors++;
         $display("[TB] FAIL rx_empty_data: got %h expected 00", rdata);
      end
      popRx();
      readReg(8'h02, v);
      checks++;
      if (v !== 8'h25) begin
         errors++;
         $display("[TB] FAIL rx_unf_status: got %h expected 25", v);
      end
      writeReg(8'h03, 8'h20);
      readReg(8'h02, v);
      checks++;
      if (v !== 8'h05) begin
         errors++;
         $display("[TB] FAIL rx_unf_clear: got %h expected 05", v);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] v;
      for (int i = 0; i < 4; i++) pushRx(8'hC0 + 8'(i));
      checks++;
      if (rx_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rx_full_ready: got %b expected 0", rx_ready);
      end
      addr = 8'h05; rdata_used = 1'b1; rx_valid = 1'b1; rx_data = 8'hCF;
      step();
      rdata_used = 1'b0; rx_valid = 1'b0;
      void'(rxQ.pop_front());
      rxQ.push_back(8'hCF);
      readReg(8'h07, v);
      checks++;
      if (v !== 8'h04) begin
         errors++;
         $display("[TB] FAIL rx_full_pushpop_level: got %h expected 04", v);
      end
      for (int i = 0; i < 4; i++) begin
         readReg(8'h05, v);
         checks++;
         if (v !== rxQ[0]) begin
            errors++;
            $display("[TB] FAIL rx_order_%0d: got %h expected %h", i, v, rxQ[0]);
         end
         popRx();
      end
      for (int i = 0; i < 4; i++) writeReg(8'h04, 8'hD0 + 8'(i));
      tx_ready = 1'b1;
      writeReg(8'h04, 8'hDF);
      tx_ready = 1'b0;
      readReg(8'h02, v);
      checks++;
      if (v !== expRead(8'h02)) begin
         errors++;
         $display("[TB] FAIL tx_full_pushpop_status: got %h expected %h", v, expRead(8'h02));
      end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tx_data !== txQ[0]) begin
            errors++;
            $display("[TB] FAIL tx_order_%0d: got %h expected %h", i, tx_data, txQ[0]);
         end
         step();
      end
      tx_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] v, a;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 5))
            0, 1: begin
               a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
               writeReg(a, 8'($urandom));
            end
            2: pushRx(8'($urandom));
            3: popRx();
            4: begin
               tx_ready = 1'b1;
               checks++;
               if (tx_valid !== (txQ.size() > 0) || tx_data !== ((txQ.size() > 0) ? txQ[0] : 8'h00)) begin
                  errors++;
                  $display("[TB] FAIL rand_tx_head: got valid=%b data=%h", tx_valid, tx_data);
               end
               step();
               tx_ready = 1'b0;
            end
            default: begin
               a = 8'($urandom_range(0, 18));
               readReg(a, v);
               checks++;
               if (v !== expRead(a)) begin
                  errors++;
                  $display("[TB] FAIL rand_read_%h: got %h expected %h", a, v, expRead(a));
               end
            end
         endcase
         checks++;
         if (gp_out !== expGp() || ctrl !== mCtrl || rx_ready !== (rxQ.size() < 4)) begin
            errors++;
            $display("[TB] FAIL rand_outputs: got gp=%h ctrl=%h rx_ready=%b expected gp=%h ctrl=%h",
                     gp_out, ctrl, rx_ready, expGp(), mCtrl);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] v;
      writeReg(8'h0F, 8'hEE);
      writeReg(8'h01, 8'h33);
      writeReg(8'h04, 8'h99);
      pushRx(8'h42);
      pushRx(8'h43);
      addr = 8'h07;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      modelReset();
      checks++;
      if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || gp_out !== 64'h0 || ctrl !== 8'h00 ||
          rdata !== 8'h00 || tx_data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL async_reset: got tx_valid=%b rx_ready=%b gp=%h ctrl=%h rdata=%h tx_data=%h",
                  tx_valid, rx_ready, gp_out, ctrl, rdata, tx_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      readReg(8'h02, v);
      checks++;
      if (v !== 8'h05) begin
         errors++;
         $display("[TB] FAIL post_reset_status: got %h expected 05", v);
      end
   endtask

   initial begin
      modelReset();
      test_reset();
      test_gp();
      test_tx_fifo();
      test_rx_fifo();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
